// File: rtl/march_patgen_pkg.sv
// Shared types and the March C- element/op table for march_patgen.
package march_patgen_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5, DONE} element_t;

    typedef enum logic [1:0] {SOLID, CHECKER, ROW, COL} bg_t;

    typedef struct packed {
        logic rd;   // 1 = read, 0 = write
        logic inv;  // 1 = inverted background
    } op_t;

    typedef struct packed {
        logic two_ops;
        logic down;
        op_t  op0;
        op_t  op1;
    } elem_info_t;

    function automatic elem_info_t elem_info(element_t e);
        elem_info_t info;
        info = '0;
        case (e)
            M0:      info = '{two_ops: 1'b0, down: 1'b0, op0: '{1'b0, 1'b0}, op1: '{1'b0, 1'b0}};
            M1:      info = '{two_ops: 1'b1, down: 1'b0, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b1}};
            M2:      info = '{two_ops: 1'b1, down: 1'b0, op0: '{1'b1, 1'b1}, op1: '{1'b0, 1'b0}};
            M3:      info = '{two_ops: 1'b1, down: 1'b1, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b1}};
            M4:      info = '{two_ops: 1'b1, down: 1'b1, op0: '{1'b1, 1'b1}, op1: '{1'b0, 1'b0}};
            M5:      info = '{two_ops: 1'b0, down: 1'b1, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b0}};
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/march_bg_gen.sv
// Combinational data-background generator: word depends only on address LSB and background kind.
module march_bg_gen
    import march_patgen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  addr0,
    input  bg_t                   bg,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-1:0] odd_bits;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_odd
        assign odd_bits[i] = 1'(i % 2);
    end

    always_comb begin
        word = '0;
        unique case (bg)
            SOLID:   word = '0;
            CHECKER: word = addr0 ? ~odd_bits : odd_bits;
            ROW:     word = {DATA_WIDTH{addr0}};
            COL:     word = odd_bits;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/march_patgen.sv
// March C- pattern generator for SRAM BIST, zero-latency op presentation.
// Define MARCH_PATGEN_BG_SWEEP_EN to sweep all four backgrounds and expose bg_idx.
module march_patgen
    import march_patgen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 4,
    parameter int unsigned MAX_ADDR   = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            bg_sel,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] check,
    output logic [MASK_WIDTH-1:0] wmask,
    output logic                  we,
    output logic                  re,
    output logic [2:0]            element,
    output logic                  done
`ifdef MARCH_PATGEN_BG_SWEEP_EN
    ,
    output logic [1:0]            bg_idx
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDR);

    element_t              elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  op_q;
    bg_t                   bg_q;

    elem_info_t            info;
    element_t              next_elem;
    logic                  next_down;
    logic                  last_addr;
    op_t                   cur_op;
    logic [DATA_WIDTH-1:0] bg_word;
    logic [DATA_WIDTH-1:0] pat;

    always_comb begin
        info      = elem_info(elem_q);
        next_elem = element_t'(elem_q + 3'd1);
        next_down = elem_info(next_elem).down;
        last_addr = info.down ? (addr_q == '0) : (addr_q == LAST_ADDR);
        cur_op    = op_q ? info.op1 : info.op0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q <= M0;
            addr_q <= '0;
            op_q   <= 1'b0;
`ifdef MARCH_PATGEN_BG_SWEEP_EN
            bg_q   <= SOLID;
`else
            bg_q   <= bg_t'(bg_sel);
`endif
        end else if (en && elem_q != DONE) begin
            if (info.two_ops && !op_q) begin
                op_q <= 1'b1;
            end else begin
                op_q <= 1'b0;
                if (!last_addr) begin
                    addr_q <= info.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                end else if (elem_q == M5) begin
                    addr_q <= '0;
`ifdef MARCH_PATGEN_BG_SWEEP_EN
                    if (bg_q != COL) begin
                        bg_q   <= bg_t'(bg_q + 2'd1);
                        elem_q <= M0;
                    end else begin
                        elem_q <= DONE;
                    end
`else
                    elem_q <= DONE;
`endif
                end else begin
                    elem_q <= next_elem;
                    addr_q <= next_down ? LAST_ADDR : '0;
                end
            end
        end
    end

    march_bg_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bg_gen (
        .addr0(addr_q[0]),
        .bg   (bg_q),
        .word (bg_word)
    );

    // DONE decodes to an all-zero op table entry, so only done gates we/re.
    always_comb begin
        pat     = cur_op.inv ? ~bg_word : bg_word;
        done    = (elem_q == DONE);
        we      = !done && !cur_op.rd;
        re      = !done && cur_op.rd;
        data    = we ? pat : '0;
        check   = re ? pat : '0;
        addr    = addr_q;
        element = elem_q;
        wmask   = '1;
    end

`ifdef MARCH_PATGEN_BG_SWEEP_EN
    assign bg_idx = bg_q;
    logic unused_bg_sel;
    assign unused_bg_sel = ^bg_sel;
`endif

endmodule

// File: tb/tb_march_patgen.sv
// Self-checking bench for march_patgen at MAX_ADDR=3, DATA_WIDTH=8.
module tb_march_patgen;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int MW   = 4;
    localparam int MAXA = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    bg_sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] check;
    logic [MW-1:0] wmask;
    logic          we;
    logic          re;
    logic [2:0]    element;
    logic          done;
`ifdef MARCH_PATGEN_BG_SWEEP_EN
    logic [1:0]    bg_idx;
`endif

    int n_pass  = 0;
    int n_total = 0;

    march_patgen #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MASK_WIDTH(MW),
        .MAX_ADDR  (MAXA)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .bg_sel (bg_sel),
        .addr   (addr),
        .data   (data),
        .check  (check),
        .wmask  (wmask),
        .we     (we),
        .re     (re),
        .element(element),
        .done   (done)
`ifdef MARCH_PATGEN_BG_SWEEP_EN
        ,
        .bg_idx (bg_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        logic [2:0] e;
        logic [3:0] a;
        bit         w;
        bit         r;
        logic [7:0] d;
        logic [7:0] c;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        rst    = 1'b1;
        bg_sel = sel;
        en     = 1'b0;
        step();
        rst    = 1'b0;
    endtask

    function automatic logic [25:0] pk(input logic [2:0] e, input logic [3:0] a, input logic w,
                                       input logic r, input logic [7:0] d, input logic [7:0] c,
                                       input logic dn);
        return {dn, e, a, w, r, d, c};
    endfunction

    function automatic logic [25:0] outs();
        return pk(element, addr, we, re, data, check, done);
    endfunction

    function automatic logic [7:0] bgw(input int sel, input int a);
        case (sel)
            0:       return 8'h00;
            1:       return (a % 2 == 1) ? 8'h55 : 8'hAA;
            2:       return (a % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'hAA;
        endcase
    endfunction

    // Walks the full sequence from the bench's own element table and a memory model.
    task automatic run_march(input int sel, input bit toggle);
        logic [7:0] mem [4];
        int nbg;
        int cyc;
        do_reset(2'(sel));
        cyc = 0;
`ifdef MARCH_PATGEN_BG_SWEEP_EN
        nbg = 4;
`else
        nbg = 1;
`endif
        for (int b = 0; b < nbg; b++) begin
            int cur;
            cur = (nbg == 4) ? b : sel;
            for (int e = 0; e < 6; e++) begin
                int nops;
                nops = (e == 0 || e == 5) ? 1 : 2;
                for (int k = 0; k <= MAXA; k++) begin
                    int a;
                    a = (e >= 3) ? MAXA - k : k;
                    for (int o = 0; o < nops; o++) begin
                        bit rd;
                        bit inv;
                        logic [7:0] wv;
                        rd  = (e != 0) && (o == 0);
                        inv = (o == 0) ? (e == 2 || e == 4) : (e == 1 || e == 3);
                        wv  = bgw(cur, a) ^ (inv ? 8'hFF : 8'h00);
                        chk("trace", outs(), pk(3'(e), 4'(a), !rd, rd, rd ? 8'h00 : wv,
                                                rd ? wv : 8'h00, 1'b0));
`ifdef MARCH_PATGEN_BG_SWEEP_EN
                        chk("bg_idx", bg_idx, 2'(b));
`endif
                        if (rd) chk("golden", check, mem[a]);
                        else mem[a] = wv;
                        if (toggle) begin
                            while (cyc % 4 == 1 || cyc % 4 == 2) begin
                                en = 1'b0;
                                step();
                                cyc++;
                                chk("frozen", outs(), pk(3'(e), 4'(a), !rd, rd, rd ? 8'h00 : wv,
                                                         rd ? wv : 8'h00, 1'b0));
                            end
                        end
                        en = 1'b1;
                        step();
                        cyc++;
                    end
                end
            end
        end
        chk("done_rise", outs(), pk(3'd6, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1));
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("done_hold", outs(), pk(3'd6, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1));
        end
        en = 1'b0;
    endtask

    initial begin
        vec_t tbl [12];
        bit   found;

        rst    = 1'b0;
        en     = 1'b0;
        bg_sel = 2'd0;

        do_reset(2'd0);
        chk("reset", outs(), pk(3'd0, 4'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0));
        chk("wmask", wmask, 4'hF);

`ifndef MARCH_PATGEN_BG_SWEEP_EN
        // CHECKER background with en gaps across M0 into M1.
        tbl[0]  = '{1, 3'd0, 4'd0, 1, 0, 8'hAA, 8'h00};
        tbl[1]  = '{0, 3'd0, 4'd1, 1, 0, 8'h55, 8'h00};
        tbl[2]  = '{0, 3'd0, 4'd1, 1, 0, 8'h55, 8'h00};
        tbl[3]  = '{1, 3'd0, 4'd1, 1, 0, 8'h55, 8'h00};
        tbl[4]  = '{1, 3'd0, 4'd2, 1, 0, 8'hAA, 8'h00};
        tbl[5]  = '{1, 3'd0, 4'd3, 1, 0, 8'h55, 8'h00};
        tbl[6]  = '{1, 3'd1, 4'd0, 0, 1, 8'h00, 8'hAA};
        tbl[7]  = '{0, 3'd1, 4'd0, 1, 0, 8'h55, 8'h00};
        tbl[8]  = '{1, 3'd1, 4'd0, 1, 0, 8'h55, 8'h00};
        tbl[9]  = '{1, 3'd1, 4'd1, 0, 1, 8'h00, 8'h55};
        tbl[10] = '{1, 3'd1, 4'd1, 1, 0, 8'hAA, 8'h00};
        tbl[11] = '{1, 3'd1, 4'd2, 0, 1, 8'h00, 8'hAA};
        do_reset(2'd1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d", i), outs(),
                pk(tbl[i].e, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c, 1'b0));
            en = tbl[i].en;
            step();
        end
        en = 1'b0;
`endif

        run_march(0, 1'b0);
        run_march(2, 1'b1);

        // Reset in the middle of M3, with a new background selected during reset.
        do_reset(2'd0);
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (element == 3'd3 && addr == 4'd2) found = 1'b1;
            else step();
        end
        chk("reach_m3_a2", found, 1'b1);
        rst    = 1'b1;
        bg_sel = 2'd3;
        step();
        rst    = 1'b0;
        en     = 1'b0;
`ifdef MARCH_PATGEN_BG_SWEEP_EN
        chk("mid_reset", outs(), pk(3'd0, 4'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0));
`else
        chk("mid_reset", outs(), pk(3'd0, 4'd0, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
